// File: rtl/cpu_bus_responder.sv
// CPU-side bus responder: address decode for internal RAM, PPU registers and PRG, plus OAM DMA.
// Optional feature: define OPEN_BUS_EN to make unmapped reads return the last cpu_data_in value.
module cpu_bus_responder (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_mem_addr,
    input  logic [7:0]  cpu_data_out,
    output logic [7:0]  cpu_data_in,
    input  logic        cpu_write_en,
    input  logic        cpu_read_en,
    output logic        cpu_stall,
    output logic [2:0]  ppu_reg_addr,
    output logic [7:0]  ppu_reg_wdata,
    output logic        ppu_reg_we,
    output logic        ppu_reg_re,
    input  logic [7:0]  ppu_reg_rdata,
    output logic [14:0] prg_addr,
    input  logic [7:0]  prg_rdata
);

    localparam int unsigned RamDepth    = 2048;
    localparam logic [15:0] DmaTrigAddr = 16'h4014;
    localparam logic [2:0]  OamDataReg  = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StAlign,
        StRd,
        StWr
    } dma_state_e;

    dma_state_e state_q;
    logic [7:0] page_q;
    logic [7:0] idx_q;
    logic [7:0] dma_data_q;
    logic [7:0] data_in_q;
    logic       stall_q;
    logic       dma_we_q;

    logic [7:0] ram [RamDepth];

    // Address decode
    logic sel_ram;
    logic sel_ppu;
    logic sel_dma;
    logic sel_prg;

    assign sel_ram = (cpu_mem_addr[15:13] == 3'b000);
    assign sel_ppu = (cpu_mem_addr[15:13] == 3'b001);
    assign sel_dma = (cpu_mem_addr == DmaTrigAddr);
    assign sel_prg = cpu_mem_addr[15];

    // Strobes are dead while DMA owns the bus; write wins over read.
    logic cpu_wr;
    logic cpu_rd;

    assign cpu_wr = !rst && !stall_q && cpu_write_en;
    assign cpu_rd = !rst && !stall_q && cpu_read_en && !cpu_write_en;

    logic [10:0] dma_ram_idx;
    logic [14:0] dma_prg_addr;

    assign dma_ram_idx  = {page_q[2:0], idx_q};
    assign dma_prg_addr = {page_q[6:0], idx_q};

    always_comb begin
        prg_addr = '0;
        if (!rst) begin
            prg_addr = stall_q ? dma_prg_addr : cpu_mem_addr[14:0];
        end
    end

    // CPU read mux
    logic [7:0] rd_data;

    always_comb begin
        rd_data = 8'h00;
        if (sel_ram) begin
            rd_data = ram[cpu_mem_addr[10:0]];
        end else if (sel_ppu) begin
            rd_data = ppu_reg_rdata;
        end else if (sel_prg) begin
            rd_data = prg_rdata;
        end else begin
`ifdef OPEN_BUS_EN
            rd_data = data_in_q;
`else
            rd_data = 8'h00;
`endif
        end
    end

    // DMA source byte for the current page/index
    logic [7:0] dma_src;

    always_comb begin
        dma_src = 8'hFF;
        if (page_q[7:5] == 3'b000) begin
            dma_src = ram[dma_ram_idx];
        end else if (page_q[7]) begin
            dma_src = prg_rdata;
        end
    end

    // PPU register port: CPU accesses pulse in the sampling cycle, DMA owns it while stalled.
    always_comb begin
        ppu_reg_addr  = '0;
        ppu_reg_wdata = '0;
        ppu_reg_we    = 1'b0;
        ppu_reg_re    = 1'b0;
        if (!rst) begin
            if (stall_q) begin
                ppu_reg_addr  = OamDataReg;
                ppu_reg_wdata = dma_data_q;
                ppu_reg_we    = dma_we_q;
            end else begin
                ppu_reg_addr  = cpu_mem_addr[2:0];
                ppu_reg_wdata = cpu_data_out;
                ppu_reg_we    = cpu_wr && sel_ppu;
                ppu_reg_re    = cpu_rd && sel_ppu;
            end
        end
    end

    // RAM is deliberately not reset so its contents survive a reset.
    always_ff @(posedge clk) begin
        if (cpu_wr && sel_ram) begin
            ram[cpu_mem_addr[10:0]] <= cpu_data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            stall_q    <= 1'b0;
            dma_we_q   <= 1'b0;
            page_q     <= 8'h00;
            idx_q      <= 8'h00;
            dma_data_q <= 8'h00;
            data_in_q  <= 8'h00;
        end else begin
            if (cpu_rd) begin
                data_in_q <= rd_data;
            end
            case (state_q)
                StIdle: begin
                    if (cpu_wr && sel_dma) begin
                        state_q <= StAlign;
                        stall_q <= 1'b1;
                        page_q  <= cpu_data_out;
                        idx_q   <= 8'h00;
                    end
                end
                StAlign: begin
                    state_q <= StRd;
                end
                StRd: begin
                    dma_data_q <= dma_src;
                    dma_we_q   <= 1'b1;
                    state_q    <= StWr;
                end
                StWr: begin
                    dma_we_q <= 1'b0;
                    idx_q    <= idx_q + 8'd1;
                    if (idx_q == 8'hFF) begin
                        state_q <= StIdle;
                        stall_q <= 1'b0;
                    end else begin
                        state_q <= StRd;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cpu_data_in = data_in_q;
    assign cpu_stall   = stall_q;

endmodule

// File: doc/cpu_bus_responder.md
CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high, with ports named as below.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cpu_mem_addr  input  16  CPU bus address.
REQ-005 cpu_data_out  input  8  write data from CPU.
REQ-006 cpu_data_in  output  8  read data to CPU, registered.
REQ-007 cpu_write_en, cpu_read_en  input  1 each  CPU write and read strobes, sampled every cycle.
REQ-008 cpu_stall  output  1  high while OAM DMA owns the bus; CPU holds its strobes low.
REQ-009 ppu_reg_addr  output  3; ppu_reg_wdata  output  8; ppu_reg_we, ppu_reg_re  output  1 each  PPU register port.
REQ-010 ppu_reg_rdata  input  8  PPU read data, combinational from PPU.
REQ-011 prg_addr  output  15; prg_rdata  input  8  cartridge PRG port, combinational data.

Function
REQ-012 Decode: $0000-$1FFF internal 2048x8 RAM (index addr[10:0]); $2000-$3FFF PPU registers (addr[2:0]); $4014 DMA trigger; $8000-$FFFF PRG (prg_addr=addr[14:0]); everything else unmapped.
REQ-013 Read latency SHALL be exactly 1 cycle: data for a read sampled at edge N appears on cpu_data_in after edge N and holds until the next read response.
REQ-014 RAM write SHALL commit at the sampling edge; a read of the same address on the next cycle SHALL return the new data.
REQ-015 PPU access SHALL drive ppu_reg_we or ppu_reg_re as a single-cycle pulse in the sampling cycle; ppu_reg_rdata is registered into cpu_data_in at that edge.
REQ-016 Writes to PRG or unmapped space SHALL be ignored; reads of $4014 are unmapped.
REQ-017 cpu_write_en and cpu_read_en both high: write SHALL win; no read response, cpu_data_in holds.
REQ-018 DMA FSM states IDLE, ALIGN, RD, WR.
REQ-019 IDLE -> ALIGN on a write to $4014: latch page P=cpu_data_out, clear 8-bit index i; cpu_stall high from the next cycle.
REQ-020 ALIGN -> RD after one cycle; RD reads source P*256+i (P[7:5]==0: RAM; P[7]==1: PRG; else $FF).
REQ-021 WR: ppu_reg_addr=4, ppu_reg_we pulse, ppu_reg_wdata=byte read in RD; i increments (8-bit wrap); after the WR with i=$FF -> IDLE.
REQ-022 A DMA SHALL last 513 cycles with cpu_stall high; cpu_stall SHALL be low in the cycle after the final WR.
REQ-023 CPU strobes during cpu_stall SHALL be ignored with no side effects.
REQ-024 A $4014 write during DMA is impossible (stalled) and SHALL be ignored.

Reset
REQ-025 On rst: FSM=IDLE, cpu_stall=0, cpu_data_in=$00, ppu_reg_we=ppu_reg_re=0, ppu_reg_addr=0, ppu_reg_wdata=$00, prg_addr=0, open-bus latch=$00.
REQ-026 Reset mid-DMA SHALL abort the transfer; cpu_stall=0 on the cycle after the reset edge; RAM contents are not cleared.

Configuration
REQ-027 Macro OPEN_BUS_EN defined: unmapped reads return the last value driven on cpu_data_in (open-bus latch).
REQ-028 OPEN_BUS_EN undefined: unmapped reads return $00; no latch logic.

Verification
REQ-029 Write $A5 to $0123, read $0923 next cycle -> cpu_data_in=$A5 one cycle after read (mirror, 1-cycle latency).
REQ-030 Read $2002 with ppu_reg_rdata=$80 -> ppu_reg_re one-cycle pulse, ppu_reg_addr=2, cpu_data_in=$80; read $3FFA -> ppu_reg_addr=2 (mirror).
REQ-031 Fill RAM $0200-$02FF with i, write $02 to $4014 -> cpu_stall high 513 cycles, 256 ppu_reg_we pulses addr 4, data $00..$FF in order.
REQ-032 Assert rst at DMA cycle 100 -> cpu_stall=0 next cycle, no further ppu_reg_we; new DMA after reset completes normally.
REQ-033 Read $8000 (prg_rdata=$4C) then $5000 -> $4C then $4C with OPEN_BUS_EN, $4C then $00 without.
REQ-034 Simultaneous read+write to $0010 with $3C -> cpu_data_in unchanged; subsequent read of $0010 returns $3C.
